// File: rtl/qed_replay_queue.sv
// rtl/qed_replay_queue.sv - QED duplicate-instruction generator between fetch and decode
//
// Captures QED-eligible instructions (R/I ALU, LW, SW) while forwarding them (ORIG).
// Replays them with shadow-register remap in DUP.
// Optional feature macro: QED_MEM_REMAP_EN adds MEM_OFFSET to duplicated LW/SW imm12.
//
// Ports:
//   clk, rst (async active-low)
//   ena                 - QED enable; 0 flushes and passes through
//   exec_dup            - request duplicate phase
//   ifu_vld, ifu_qed_instruction - fetched instruction
//   stall_IF            - decode back-pressure, holds outputs
//   qed_vld, qed_ifu_instruction - registered output instruction
//   qed_ifu_stall       - fetch hold (DUP or FIFO full)
//   qed_count           - FIFO occupancy
//   qed_done            - one-cycle pulse after the last replay pop
module qed_replay_queue #(
    parameter int          DEPTH      = 8,
    parameter int          REG_OFFSET = 16,
    parameter logic [11:0] MEM_OFFSET = 12'h400
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       exec_dup,
    input  logic                       ifu_vld,
    input  logic [31:0]                ifu_qed_instruction,
    input  logic                       stall_IF,
    output logic                       qed_vld,
    output logic [31:0]                qed_ifu_instruction,
    output logic                       qed_ifu_stall,
    output logic [$clog2(DEPTH):0]     qed_count,
    output logic                       qed_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef enum logic {ORIG, DUP} state_t;

    state_t        state;
    logic [31:0]   fifo [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          accept;
    logic          push;
    logic          pop;

    function automatic logic is_eligible(input logic [31:0] ins);
        case (ins[6:0])
            OP_R, OP_I: return 1'b1;
            OP_LW, OP_SW: return ins[14:12] == 3'b010;
            default: return 1'b0;
        endcase
    endfunction

    // x0 must stay x0 so the duplicate keeps its hardwired-zero semantics.
    function automatic logic [4:0] remap(input logic [4:0] r);
        return (r == 5'd0) ? 5'd0 : r + 5'(REG_OFFSET);
    endfunction

    // Only eligible instructions are stored, so the opcode alone selects the format.
    function automatic logic [31:0] dup_xform(input logic [31:0] ins);
        logic [31:0] o;
        logic [11:0] imm;
        o   = ins;
        imm = 12'd0;
        case (ins[6:0])
            OP_R: begin
                o[11:7]  = remap(ins[11:7]);
                o[19:15] = remap(ins[19:15]);
                o[24:20] = remap(ins[24:20]);
            end
            OP_I, OP_LW: begin
                o[11:7]  = remap(ins[11:7]);
                o[19:15] = remap(ins[19:15]);
            end
            OP_SW: begin
                o[19:15] = remap(ins[19:15]);
                o[24:20] = remap(ins[24:20]);
            end
            default: o = ins;
        endcase
`ifdef QED_MEM_REMAP_EN
        if (ins[6:0] == OP_LW) begin
            o[31:20] = ins[31:20] + MEM_OFFSET;
        end else if (ins[6:0] == OP_SW) begin
            // SW splits imm12 across imm[11:5] and imm[4:0]; add as one value then split.
            imm      = {ins[31:25], ins[11:7]} + MEM_OFFSET;
            o[31:25] = imm[11:5];
            o[11:7]  = imm[4:0];
        end
`else
        imm = MEM_OFFSET;
`endif
        return o;
    endfunction

    logic unused_imm;
    assign unused_imm = ^dup_xform(32'd0);

    assign qed_ifu_stall = (state == DUP) | (count == CW'(DEPTH));
    assign accept        = ifu_vld & ~stall_IF & ~qed_ifu_stall;
    assign push          = accept & ena & is_eligible(ifu_qed_instruction);
    assign pop           = (state == DUP) & ena & ~stall_IF;
    assign count_nxt     = count + CW'(push) - CW'(pop);
    assign qed_count     = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= ifu_qed_instruction;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ORIG;
            qed_vld             <= 1'b0;
            qed_ifu_instruction <= 32'h0000_0013;
            count               <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            qed_done            <= 1'b0;
        end else begin
            qed_done <= 1'b0;
            if (!stall_IF) begin
                if (state == DUP) begin
                    qed_vld <= pop;
                    if (pop) begin
                        qed_ifu_instruction <= dup_xform(fifo[rd_ptr]);
                    end
                end else begin
                    qed_vld <= accept;
                    if (accept) begin
                        qed_ifu_instruction <= ifu_qed_instruction;
                    end
                end
            end
            if (!ena) begin
                // Disable aborts silently: flush and return to ORIG without qed_done.
                state  <= ORIG;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count_nxt;
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case (state)
                    ORIG: begin
                        // count_nxt includes a same-cycle push, so it joins the replay.
                        if ((exec_dup && count_nxt != '0) || count_nxt == CW'(DEPTH)) begin
                            state <= DUP;
                        end
                    end
                    DUP: begin
                        if (pop && count == CW'(1)) begin
                            state    <= ORIG;
                            qed_done <= 1'b1;
                        end
                    end
                    default: state <= ORIG;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qed_replay_queue.sv
// tb/tb_qed_replay_queue.sv - self-checking bench for qed_replay_queue
module tb_qed_replay_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        exec_dup = 1'b0;
    logic        ifu_vld = 1'b0;
    logic [31:0] ifu_qed_instruction = 32'h13;
    logic        stall_IF = 1'b0;
    logic        qed_vld;
    logic [31:0] qed_ifu_instruction;
    logic        qed_ifu_stall;
    logic [3:0]  qed_count;
    logic        qed_done;

    always #5 clk = ~clk;

    qed_replay_queue #(.DEPTH(DEPTH), .REG_OFFSET(16), .MEM_OFFSET(12'h400)) dut (
        .clk(clk), .rst(rst), .ena(ena), .exec_dup(exec_dup),
        .ifu_vld(ifu_vld), .ifu_qed_instruction(ifu_qed_instruction),
        .stall_IF(stall_IF), .qed_vld(qed_vld),
        .qed_ifu_instruction(qed_ifu_instruction), .qed_ifu_stall(qed_ifu_stall),
        .qed_count(qed_count), .qed_done(qed_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit elig(input logic [31:0] ins);
        int op;
        op = int'(ins[6:0]);
        if (op == 'h33 || op == 'h13) return 1;
        if ((op == 'h03 || op == 'h23) && ins[14:12] == 3'd2) return 1;
        return 0;
    endfunction

    function automatic logic [4:0] rmap(input logic [4:0] r);
        int v;
        v = (r == 0) ? 0 : (int'(r) + 16) % 32;
        return v[4:0];
    endfunction

    function automatic logic [31:0] dupx(input logic [31:0] ins);
        logic [31:0] o;
        int op;
        int imm;
        o  = ins;
        op = int'(ins[6:0]);
        if (op == 'h33 || op == 'h13 || op == 'h03) o[11:7] = rmap(ins[11:7]);
        o[19:15] = rmap(ins[19:15]);
        if (op == 'h33 || op == 'h23) o[24:20] = rmap(ins[24:20]);
`ifdef QED_MEM_REMAP_EN
        if (op == 'h03) begin
            imm = (int'(ins[31:20]) + 'h400) % 4096;
            o[31:20] = imm[11:0];
        end
        if (op == 'h23) begin
            imm = (int'({ins[31:25], ins[11:7]}) + 'h400) % 4096;
            o[31:25] = imm[11:5];
            o[11:7]  = imm[4:0];
        end
`else
        imm = 0;
`endif
        return o;
    endfunction

    logic [31:0] mq[$];
    bit          m_dup = 0;
    logic        m_vld = 1'b0;
    logic [31:0] m_instr = 32'h13;
    logic        m_done = 1'b0;
    bit          upd = 0;
    bit          was_dup, m_stl, m_acc;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_dup = 0; m_vld = 0; m_instr = 32'h13; m_done = 0; upd = 0;
        end else begin
            was_dup = m_dup;
            m_stl   = m_dup || mq.size() == DEPTH;
            m_acc   = ifu_vld && !stall_IF && !m_stl;
            m_done  = 0;
            upd     = !stall_IF;
            if (!stall_IF) begin
                if (was_dup && ena) begin
                    m_vld   = 1;
                    m_instr = dupx(mq.pop_front());
                    if (mq.size() == 0) begin
                        m_dup  = 0;
                        m_done = 1;
                    end
                end else begin
                    m_vld = m_acc;
                    if (m_acc) m_instr = ifu_qed_instruction;
                end
            end
            if (!ena) begin
                mq.delete();
                m_dup = 0;
            end else if (!was_dup) begin
                if (m_acc && elig(ifu_qed_instruction)) mq.push_back(ifu_qed_instruction);
                if ((exec_dup && mq.size() > 0) || mq.size() == DEPTH) m_dup = 1;
            end
        end
    end

    // ---------------- compare process + observation log ----------------
    logic [31:0] out_log[$];
    int          done_cnt = 0;
    int          peak = 0;
    int          stall_cyc = 0;
    bit          seen_full = 0;

    initial forever begin
        @(negedge clk);
        chk("vld", {31'd0, qed_vld}, {31'd0, m_vld});
        chk("instr", qed_ifu_instruction, m_instr);
        chk("count", {28'd0, qed_count}, mq.size());
        chk("stall", {31'd0, qed_ifu_stall}, {31'd0, m_dup || mq.size() == DEPTH});
        chk("done", {31'd0, qed_done}, {31'd0, m_done});
        if (qed_vld && upd) out_log.push_back(qed_ifu_instruction);
        if (qed_done) done_cnt++;
        if (int'(qed_count) > peak) peak = int'(qed_count);
        if (qed_ifu_stall) stall_cyc++;
        if (qed_ifu_stall && qed_count == 4'd8) seen_full = 1;
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic e, input logic v, input logic [31:0] ins,
                       input logic xd, input logic st);
        @(negedge clk); #1;
        ena = e; ifu_vld = v; ifu_qed_instruction = ins; exec_dup = xd; stall_IF = st;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 32'h13, 0, 0);
    endtask

    task automatic clear_obs();
        @(negedge clk); #1;
        out_log.delete(); done_cnt = 0; peak = 0; stall_cyc = 0; seen_full = 0;
    endtask

    function automatic logic [31:0] addi_same(input int i);
        return 32'((i << 20) | (i << 15) | (i << 7) | 'h13);
    endfunction

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_instr", qed_ifu_instruction, 32'h0000_0013);
        chk("reset_vld", {31'd0, qed_vld}, 32'd0);
        chk("reset_count", {28'd0, qed_count}, 32'd0);
        chk("reset_stall", {31'd0, qed_ifu_stall}, 32'd0);
        chk("reset_done", {31'd0, qed_done}, 32'd0);
        #1 rst = 1'b1;

        // Basic replay
        clear_obs();
        cyc(1, 1, 32'h003100B3, 0, 0);
        cyc(1, 0, 32'h13, 1, 0);
        idle(4);
        chk("t1_orig", out_log[0], 32'h003100B3);
        chk("t1_dup", out_log[1], 32'h013908B3);
        chk("t1_stall_cycles", stall_cyc, 1);
        chk("t1_done", done_cnt, 1);

        // Ineligible mixed in
        clear_obs();
        cyc(1, 1, 32'h00130293, 0, 0);
        cyc(1, 1, 32'h00000063, 0, 0);
        cyc(1, 1, 32'h00500393, 0, 0);
        cyc(1, 1, 32'h0000006F, 0, 0);
        cyc(1, 1, 32'hFFFF8F93, 0, 0);
        cyc(1, 0, 32'h13, 1, 0);
        idle(6);
        chk("t2_len", out_log.size(), 8);
        chk("t2_beq_pass", out_log[1], 32'h00000063);
        chk("t2_dup0", out_log[5], 32'h001B0A93);
        chk("t2_dup1", out_log[6], 32'h00500B93);
        chk("t2_dup2", out_log[7], 32'hFFF78793);
        chk("t2_peak", peak, 3);
        chk("t2_done", done_cnt, 1);

        // Full auto-drain
        clear_obs();
        for (int i = 1; i <= 8; i++) cyc(1, 1, addi_same(i), 0, 0);
        idle(12);
        chk("t3_len", out_log.size(), 16);
        chk("t3_full_stall", {31'd0, seen_full}, 32'd1);
        chk("t3_last_dup", out_log[15], 32'h008C0C13);
        chk("t3_count_end", {28'd0, qed_count}, 32'd0);
        chk("t3_done", done_cnt, 1);

        // x0 and memory remap
        clear_obs();
        cyc(1, 1, 32'h00402003, 0, 0);
        cyc(1, 1, 32'h0050A423, 0, 0);
        cyc(1, 0, 32'h13, 1, 0);
        idle(5);
`ifdef QED_MEM_REMAP_EN
        chk("t4_lw_dup", out_log[2], 32'h40402003);
        chk("t4_sw_dup", out_log[3], 32'h4158A423);
`else
        chk("t4_lw_dup", out_log[2], 32'h00402003);
        chk("t4_sw_dup", out_log[3], 32'h0158A423);
`endif

        // Back-pressure mid-replay
        clear_obs();
        for (int i = 1; i <= 4; i++) cyc(1, 1, addi_same(i), 0, 0);
        cyc(1, 0, 32'h13, 1, 0);
        cyc(1, 0, 32'h13, 0, 0);
        cyc(1, 0, 32'h13, 0, 1);
        cyc(1, 0, 32'h13, 0, 1);
        chk("t5_hold_count", {28'd0, qed_count}, 32'd3);
        chk("t5_hold_instr", qed_ifu_instruction, 32'h00188893);
        cyc(1, 0, 32'h13, 0, 1);
        idle(6);
        chk("t5_len", out_log.size(), 8);
        chk("t5_dup_first", out_log[4], 32'h00188893);
        chk("t5_dup_last", out_log[7], 32'h004A0A13);

        // Abort by ena drop with 4 queued in DUP
        clear_obs();
        for (int i = 1; i <= 4; i++) cyc(1, 1, addi_same(i), 0, 0);
        cyc(1, 0, 32'h13, 1, 1);
        cyc(0, 0, 32'h13, 0, 0);
        cyc(1, 1, 32'h003100B3, 0, 0);
        chk("t6_count", {28'd0, qed_count}, 32'd0);
        chk("t6_stall", {31'd0, qed_ifu_stall}, 32'd0);
        idle(3);
        chk("t6_pass", out_log[out_log.size()-1], 32'h003100B3);

        // Abort by reset with 4 queued in DUP
        clear_obs();
        for (int i = 1; i <= 4; i++) cyc(1, 1, addi_same(i), 0, 0);
        cyc(1, 0, 32'h13, 1, 1);
        @(negedge clk); #1;
        rst = 1'b0; stall_IF = 1'b0; exec_dup = 1'b0;
        #2;
        chk("t7_count", {28'd0, qed_count}, 32'd0);
        chk("t7_stall", {31'd0, qed_ifu_stall}, 32'd0);
        chk("t7_instr", qed_ifu_instruction, 32'h0000_0013);
        @(negedge clk); #1 rst = 1'b1;
        cyc(1, 1, 32'h00500393, 0, 0);
        idle(3);
        chk("t6_t7_no_done", done_cnt, 0);
        chk("t7_pass", out_log[out_log.size()-1], 32'h00500393);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
